// File: rtl/tinyqv_qspi_pkg.sv
// Shared definitions for the TinyQV QSPI responder: command codes, bus address width and FSM states.
package tinyqv_qspi_pkg;

   localparam logic [7:0]  CMD_READ_QUAD  = 8'hEB;
   localparam logic [7:0]  CMD_WRITE_QUAD = 8'h38;
   localparam int unsigned SPI_ADDR_BITS  = 24;
   localparam int unsigned ADDR_NIBBLES   = SPI_ADDR_BITS / 4;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StDummy,
      StRead,
      StWrite,
      StIgnore
   } qspi_state_e;

endpackage

// File: rtl/tinyqv_responder_mem.sv
// Single-port byte RAM with synchronous write and 1-cycle registered read; a vendor BRAM drops in here.
module tinyqv_responder_mem #(
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [7:0]           wdata_i,
   output logic [7:0]           rdata_o
);

   logic [7:0] mem_q [2**ADDR_BITS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/tinyqv_qspi_responder.sv
// Device end of the TinyQV QSPI bus: decodes quad read (EB) and quad write (38) into a small RAM.
// The SPI clock is oversampled in the clk domain; ADDR_BITS must be at least 5.
module tinyqv_qspi_responder
   import tinyqv_qspi_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 12,
   parameter int unsigned DUMMY_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       spi_clk_in,
   input  logic       spi_select_n,
   input  logic [3:0] spi_data_in,
   output logic [3:0] spi_data_out,
   output logic [3:0] spi_data_oe,
   output logic       busy
);

   qspi_state_e          state_q;
   logic                 spi_clk_q;
   logic                 spi_rise;
   logic                 spi_fall;
   logic [7:0]           cnt_q;
   logic [3:0]           cmd_hi_q;
   logic [3:0]           wr_hi_q;
   logic                 is_write_q;
   logic [7:0]           cmd_d;
   logic [ADDR_BITS-1:0] addr_q;
   logic [ADDR_BITS-1:0] addr_shift_d;
   logic [ADDR_BITS-1:0] addr_inc_d;

   logic                 mem_we_q;
   logic [ADDR_BITS-1:0] mem_waddr_q;
   logic [7:0]           mem_wdata_q;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [7:0]           mem_rdata;

   always_comb begin
      spi_rise     = spi_clk_in & ~spi_clk_q;
      spi_fall     = ~spi_clk_in & spi_clk_q;
      cmd_d        = {cmd_hi_q, spi_data_in};
      addr_shift_d = {addr_q[ADDR_BITS-5:0], spi_data_in};
      addr_inc_d   = addr_q + ADDR_BITS'(1);
      // The read port tracks addr_q continuously, so the next byte is always pre-fetched.
      mem_addr     = mem_we_q ? mem_waddr_q : addr_q;
      busy         = (state_q != StIdle);
   end

   tinyqv_responder_mem #(
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we_q),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         spi_clk_q    <= 1'b0;
         cnt_q        <= '0;
         cmd_hi_q     <= '0;
         wr_hi_q      <= '0;
         is_write_q   <= 1'b0;
         addr_q       <= '0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         spi_data_out <= 4'h0;
         spi_data_oe  <= 4'h0;
      end else begin
         spi_clk_q <= spi_clk_in;
         mem_we_q  <= 1'b0;
         // Deselect overrides any SPI edge seen in the same cycle.
         if (spi_select_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            spi_data_out <= 4'h0;
            spi_data_oe  <= 4'h0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q <= StCmd;
                  cnt_q   <= '0;
               end
               StCmd: begin
                  if (spi_rise) begin
                     cmd_hi_q <= spi_data_in;
                     if (cnt_q == 8'd1) begin
                        cnt_q <= '0;
                        if (cmd_d == CMD_READ_QUAD) begin
                           is_write_q <= 1'b0;
                           state_q    <= StAddr;
                        end else if (cmd_d == CMD_WRITE_QUAD) begin
                           is_write_q <= 1'b1;
                           state_q    <= StAddr;
                        end else begin
                           state_q <= StIgnore;
                        end
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               StAddr: begin
                  if (spi_rise) begin
                     addr_q <= addr_shift_d;
                     if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
                        cnt_q <= '0;
                        if (is_write_q) begin
                           state_q <= StWrite;
                        end else if (DUMMY_CYCLES == 0) begin
                           state_q <= StRead;
                        end else begin
                           state_q <= StDummy;
                        end
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               StDummy: begin
                  if (spi_rise) begin
                     if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StRead;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               StRead: begin
                  if (spi_fall) begin
                     spi_data_oe <= 4'hF;
                     if (!cnt_q[0]) begin
                        spi_data_out <= mem_rdata[7:4];
                        cnt_q        <= 8'd1;
                     end else begin
                        spi_data_out <= mem_rdata[3:0];
                        cnt_q        <= '0;
                        addr_q       <= addr_inc_d;
                     end
                  end
               end
               StWrite: begin
                  if (spi_rise) begin
                     if (!cnt_q[0]) begin
                        wr_hi_q <= spi_data_in;
                        cnt_q   <= 8'd1;
                     end else begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= addr_q;
                        mem_wdata_q <= {wr_hi_q, spi_data_in};
                        addr_q      <= addr_inc_d;
                        cnt_q       <= '0;
                     end
                  end
               end
               StIgnore: begin
                  state_q <= StIgnore;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tinyqv_qspi_responder.sv
// Directed bench for the QSPI responder: bus-level writes/reads against a byte model and a nibble
// scoreboard, covering wrap, unknown command, partial byte, reset mid-read and two SPI clock rates.
module tb_tinyqv_qspi_responder;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       spi_clk_in = 1'b0;
   logic       spi_select_n = 1'b1;
   logic [3:0] spi_data_in = 4'h0;
   logic [3:0] spi_data_out;
   logic [3:0] spi_data_oe;
   logic       busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int half   = 2;

   logic [7:0] model [4096];
   logic [3:0] exp_q [$];
   logic [3:0] obs_d;
   logic [3:0] obs_d_late;
   logic [3:0] obs_oe;
   logic       obs_busy;

   tinyqv_qspi_responder #(
      .ADDR_BITS    (12),
      .DUMMY_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .spi_clk_in   (spi_clk_in),
      .spi_select_n (spi_select_n),
      .spi_data_in  (spi_data_in),
      .spi_data_out (spi_data_out),
      .spi_data_oe  (spi_data_oe),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One SPI clock: data set while low, sampled by the responder at the rise.
   task automatic nib(input logic [3:0] d);
      spi_data_in = d;
      repeat (half) @(negedge clk);
      obs_d      = spi_data_out;
      obs_oe     = spi_data_oe;
      obs_busy   = busy;
      spi_clk_in = 1'b1;
      @(negedge clk);
      obs_d_late = spi_data_out;
      repeat (half - 1) @(negedge clk);
      spi_clk_in = 1'b0;
   endtask

   task automatic sel();
      @(negedge clk);
      spi_select_n = 1'b0;
      @(negedge clk);
      check("busy_rise", 32'(busy), 32'd1);
      @(negedge clk);
   endtask

   task automatic desel();
      @(negedge clk);
      spi_select_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_oe", 32'(spi_data_oe), 32'd0);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
      nib(cmd[7:4]);
      nib(cmd[3:0]);
      for (int i = 5; i >= 0; i--) begin
         nib(a[4*i +: 4]);
         check("hdr_oe", 32'(obs_oe), 32'd0);
      end
   endtask

   task automatic write_bytes(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1,
                              input int n);
      logic [7:0]  b;
      logic [11:0] ai;
      sel();
      send_hdr(8'h38, a);
      for (int i = 0; i < n; i++) begin
         b  = (i == 0) ? b0 : b1;
         ai = a[11:0] + 12'(i);
         nib(b[7:4]);
         nib(b[3:0]);
         check("wr_oe", 32'(obs_oe), 32'd0);
         model[ai] = b;
      end
      desel();
   endtask

   task automatic read_bytes(input logic [23:0] a, input int n);
      logic [11:0] ai;
      logic [3:0]  e;
      sel();
      send_hdr(8'hEB, a);
      repeat (4) begin
         nib(4'h0);
         check("dummy_oe", 32'(obs_oe), 32'd0);
      end
      for (int i = 0; i < n; i++) begin
         ai = a[11:0] + 12'(i);
         exp_q.push_back(model[ai][7:4]);
         exp_q.push_back(model[ai][3:0]);
      end
      for (int k = 0; k < 2 * n; k++) begin
         nib(4'h0);
         e = exp_q.pop_front();
         check("data_oe", 32'(obs_oe), 32'hF);
         check("data_nib", 32'(obs_d), 32'(e));
         check("data_stable", 32'(obs_d_late), 32'(e));
      end
      desel();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_out", 32'(spi_data_out), 32'd0);
      check("rst_oe", 32'(spi_data_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Write then read at the minimum SPI period, then again at a slow period.
      half = 2;
      write_bytes(24'h000010, 8'hA5, 8'h3C, 2);
      read_bytes(24'h000010, 2);
      half = 5;
      read_bytes(24'h000010, 2);
      half = 2;

      // Address wrap at the top of the 4 KiB store.
      write_bytes(24'h000FFF, 8'h11, 8'h22, 2);
      read_bytes(24'h000FFF, 2);
      read_bytes(24'h000000, 1);

      // Half-written byte is dropped on deselect.
      write_bytes(24'h000020, 8'h77, 8'h00, 1);
      sel();
      send_hdr(8'h38, 24'h000020);
      nib(4'hF);
      desel();
      read_bytes(24'h000020, 1);

      // Unknown command: no drive, busy held until deselect, memory untouched.
      sel();
      nib(4'h9);
      nib(4'hF);
      for (int i = 0; i < 8; i++) begin
         nib(4'(i + 3));
         check("ign_oe", 32'(obs_oe), 32'd0);
         check("ign_busy", 32'(obs_busy), 32'd1);
      end
      desel();
      read_bytes(24'h000010, 2);
      read_bytes(24'h000020, 1);

      // Reset asserted in the middle of a read data phase.
      sel();
      send_hdr(8'hEB, 24'h000010);
      repeat (4) nib(4'h0);
      nib(4'h0);
      check("pre_rst_nib", 32'(obs_d), 32'hA);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("async_rst_oe", 32'(spi_data_oe), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      spi_select_n = 1'b1;
      spi_clk_in   = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      read_bytes(24'h000010, 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tinyqv_qspi_responder.md
# tinyqv_qspi_responder

Behavioural QSPI responder: the device end of the TinyQV QSPI bus, answering the quad read and write transactions the memory controller issues. It holds a small byte-addressed RAM. It decodes command, address, dummy and data phases from the bus pins, all sampled in the system clock domain. It is used as a synthesizable flash/PSRAM stand-in in FPGA builds and as the bus model in core-level benches.

## Interface
Parameters:
- ADDR_BITS, 12: backing store is 2**ADDR_BITS bytes; higher address bits are ignored.
- DUMMY_CYCLES, 4: SPI clock rising edges between the last address nibble and the first read data nibble.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset. Asynchronous, active-low.
- spi_clk_in  input  1  QSPI clock from the initiator. It is synchronous to clk and has a period of at least 4 clk.
- spi_select_n  input  1  chip select, active-low.
- spi_data_in  input  4  io[3:0] driven by the initiator.
- spi_data_out  output  4  io[3:0] driven by the responder.
- spi_data_oe  output  4  output enables. Either 4'hF or 4'h0.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Edge detection: spi_clk_in is registered once into a delayed copy.
  - The rising edge is delayed=0 and input=1.
  - The falling edge is delayed=1 and input=0.
  - On a rising edge, spi_data_in is sampled in the same clk cycle.
- Bit order: every field is sent MSB nibble first, one nibble per rising edge.
- FSM states: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
- IDLE -> CMD: when spi_select_n is low. The nibble counter is cleared.
- CMD: collect 2 nibbles, then decode.
  - 8'hEB -> ADDR (read).
  - 8'h38 -> ADDR (write).
  - Any other value -> IGNORE.
- ADDR: collect 6 nibbles (24 bits) and keep addr[ADDR_BITS-1:0].
  - On the 6th nibble, go to DUMMY (read) or WRITE (write).
  - Issue the memory read of addr on that same cycle.
- DUMMY: count DUMMY_CYCLES rising edges, then go to READ.
  - If DUMMY_CYCLES=0, go directly to READ.
- READ: on each falling edge, drive the next nibble and set oe=4'hF.
  - The high nibble of mem[addr] goes out first, then the low nibble.
  - After the low nibble: addr increments and the next byte read is issued.
  - The next byte is ready before the next falling edge, guaranteed by the ≥4-clk SPI period.
- WRITE: on each rising edge, capture a nibble.
  - On the 2nd nibble, write {hi, lo} to mem[addr], then increment addr.
- IGNORE: no drive, no memory access, until deselect.
- Address wrap: addr increments modulo 2**ADDR_BITS, so (2**ADDR_BITS)-1 -> 0.
- Deselect: spi_select_n high in any state -> IDLE on the next clk.
  - oe=0 and the nibble counters are cleared.
  - A half-collected write byte is discarded (no write).
- Simultaneous select rising and SPI clock edge: deselect wins and the edge is ignored.
- Reset: asynchronous. The FSM goes to IDLE and all counters clear.
  - Memory contents are not cleared and are unspecified after power-up.

## Timing
- Reset values: spi_data_out=4'h0, spi_data_oe=4'h0, busy=0.
- Output update: spi_data_out and spi_data_oe are registered.
  - They update in the clk cycle after the falling-edge detect.
  - Worst-case delay is 2 clk from the pin's falling edge.
- Read turnaround: oe rises at the first falling edge after the last dummy rising edge. It stays high until deselect.
- Write commit: the memory write occurs 1 clk after the detect of the second nibble's rising edge.
- busy: rises the clk after select falls and falls the clk after select rises.
- Initiator obligations:
  - spi_clk_in must be low at select assertion.
  - spi_clk_in must have ≥2 clk high and ≥2 clk low.

## Structure
- Shared package tinyqv_qspi_pkg:
  - Command constants CMD_READ_QUAD=8'hEB and CMD_WRITE_QUAD=8'h38.
  - The FSM state enum.
  - The address width constant 24.
- Sub-module tinyqv_responder_mem:
  - Single-port sync RAM with 2**ADDR_BITS bytes, byte write enable and 1-cycle read latency.
  - It is replaceable by a vendor BRAM.

## Test plan
- Write then read:
  - Stimulus: write 38, address 000010, data A5 3C, deselect; then read EB, address 000010, 4 dummy cycles.
  - Required response: the read returns nibbles A,5,3,C; oe=F during the data phase only.
- Wrap-around:
  - Stimulus: with ADDR_BITS=12, write 11 22 at address 000FFF; then read 2 bytes from 000FFF.
  - Required response: the read returns 11 then 22, with mem[0]=22.
- Unknown command:
  - Stimulus: command 9F followed by 8 nibbles.
  - Required response: oe stays 0 throughout, memory is unchanged, busy stays high until deselect.
- Partial byte:
  - Stimulus: write to address 000020 with a single nibble F, then deselect.
  - Required response: mem[20] is unchanged; the next transaction decodes normally.
- Reset mid-read:
  - Stimulus: drop rstn during the READ phase.
  - Required response: oe=0 and busy=0 asynchronously; after release, a new EB transaction returns correct data.
- Slow and minimum clocks:
  - Stimulus: run the spi_clk_in period at 4 clk and at 10 clk.
  - Required response: identical read data; every nibble is stable at each rising edge.
